// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst-master state type.
package axi_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_RDATA,
        ST_AW,
        ST_WDATA,
        ST_BRESP
    } state_t;

    // Worst response wins: the encodings are ordered by severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-channel AXI4 INCR burst initiator: one command in, one AR/R or AW/W/B
// exchange out, with the data beats streamed through valid/ready ports.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit STRICT_LAST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [3:0]        cmd_wstrb,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_data,

    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [31:0]       rd_data,
    output logic              rd_last,

    output logic              done_valid,
    output logic [1:0]        done_resp,
    output logic              done_err,

    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,

    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,

    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,

    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,

    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        len_reg;
    logic [7:0]        cnt_reg;
    logic [3:0]        strb_reg;
    logic [1:0]        resp_acc_reg;
    logic              err_acc_reg;
    logic              arvalid_reg;
    logic              awvalid_reg;
    logic              bready_reg;
    logic              done_valid_reg;
    logic [1:0]        done_resp_reg;
    logic              done_err_reg;

    logic              in_rdata;
    logic              in_wdata;
    logic              last_beat;
    logic              r_hs;
    logic              w_hs;
    logic              b_hs;
    logic [1:0]        r_resp_next;
    logic              r_err_next;

    assign in_rdata  = (state_reg == ST_RDATA);
    assign in_wdata  = (state_reg == ST_WDATA);
    assign last_beat = (cnt_reg == 8'd0);

    assign r_hs = in_rdata && m_axi_rvalid && rd_ready;
    assign w_hs = in_wdata && wr_valid && m_axi_wready;
    assign b_hs = bready_reg && m_axi_bvalid;

    // The FSM counts beats itself; rlast is only checked, never trusted.
    assign r_resp_next = resp_max(resp_acc_reg, m_axi_rresp);
    assign r_err_next  = err_acc_reg | (STRICT_LAST && (m_axi_rlast != last_beat));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            len_reg        <= 8'd0;
            cnt_reg        <= 8'd0;
            strb_reg       <= 4'd0;
            resp_acc_reg   <= AXI_RESP_OKAY;
            err_acc_reg    <= 1'b0;
            arvalid_reg    <= 1'b0;
            awvalid_reg    <= 1'b0;
            bready_reg     <= 1'b0;
            done_valid_reg <= 1'b0;
            done_resp_reg  <= AXI_RESP_OKAY;
            done_err_reg   <= 1'b0;
        end else begin
            done_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_reg      <= cmd_addr & WORD_MASK;
                        len_reg       <= cmd_len;
                        cnt_reg       <= cmd_len;
                        strb_reg      <= cmd_wstrb;
                        resp_acc_reg  <= AXI_RESP_OKAY;
                        err_acc_reg   <= 1'b0;
                        done_resp_reg <= AXI_RESP_OKAY;
                        done_err_reg  <= 1'b0;
                        if (cmd_we) begin
                            awvalid_reg <= 1'b1;
                            state_reg   <= ST_AW;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        resp_acc_reg <= r_resp_next;
                        err_acc_reg  <= r_err_next;
                        if (last_beat) begin
                            done_valid_reg <= 1'b1;
                            done_resp_reg  <= r_resp_next;
                            done_err_reg   <= r_err_next;
                            state_reg      <= ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        awvalid_reg <= 1'b0;
                        state_reg   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            bready_reg <= 1'b1;
                            state_reg  <= ST_BRESP;
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                end
                ST_BRESP: begin
                    if (b_hs) begin
                        bready_reg     <= 1'b0;
                        resp_acc_reg   <= resp_max(resp_acc_reg, m_axi_bresp);
                        done_valid_reg <= 1'b1;
                        done_resp_reg  <= resp_max(resp_acc_reg, m_axi_bresp);
                        done_err_reg   <= err_acc_reg;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_reg == ST_IDLE);
    assign done_valid = done_valid_reg;
    assign done_resp  = done_resp_reg;
    assign done_err   = done_err_reg;

    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awlen   = len_reg;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;

    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arlen   = len_reg;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;

    // Data channels are pure pass-through, gated so nothing leaks outside a burst.
    assign m_axi_wvalid = in_wdata && wr_valid;
    assign wr_ready     = in_wdata && m_axi_wready;
    assign m_axi_wdata  = in_wdata ? wr_data : 32'd0;
    assign m_axi_wstrb  = in_wdata ? strb_reg : 4'd0;
    assign m_axi_wlast  = in_wdata && last_beat;
    assign m_axi_bready = bready_reg;

    assign rd_valid     = in_rdata && m_axi_rvalid;
    assign m_axi_rready = in_rdata && rd_ready;
    assign rd_data      = in_rdata ? m_axi_rdata : 32'd0;
    assign rd_last      = in_rdata && m_axi_rlast;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master against a small AXI memory responder,
// with read-data and completion scoreboards.
module tb_axi_burst_master;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        done_err;

    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;

    axi_burst_master #(.ADDR_W(32), .STRICT_LAST(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wstrb(cmd_wstrb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int w_early = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rexp_t;

    rexp_t       rq[$];
    logic [2:0]  dq[$];
    logic [31:0] wq[$];

    logic [31:0] exp_addr = '0;
    logic [7:0]  exp_len = '0;
    logic [8:0]  err_beat = 9'h100;
    logic [8:0]  inj_last = 9'h100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Memory responder: ARREADY/AWREADY when idle, RVALID held until taken,
    // WREADY once the write address is accepted, BVALID after the final beat.
    logic [31:0] mem [0:1023];
    logic        rd_active, wr_active, bvalid_r;
    logic [7:0]  rd_len, rd_beat, wr_beat;
    logic [9:0]  rd_idx, wr_idx;

    assign m_axi_arready = !rd_active;
    assign m_axi_rvalid  = rd_active;
    assign m_axi_rdata   = rd_active ? mem[rd_idx] : 32'd0;
    assign m_axi_rresp   = (rd_active && ({1'b0, rd_beat} == err_beat)) ? 2'd2 : 2'd0;
    assign m_axi_rlast   = rd_active && (inj_last[8] ? (rd_beat == rd_len)
                                                     : ({1'b0, rd_beat} == inj_last));
    assign m_axi_awready = !wr_active && !bvalid_r;
    assign m_axi_wready  = wr_active;
    assign m_axi_bvalid  = bvalid_r;
    assign m_axi_bresp   = 2'd0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_active <= 1'b0;
            wr_active <= 1'b0;
            bvalid_r  <= 1'b0;
            rd_len    <= '0;
            rd_beat   <= '0;
            wr_beat   <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                check("araddr", m_axi_araddr, exp_addr);
                check("arlen", {24'd0, m_axi_arlen}, {24'd0, exp_len});
                rd_active <= 1'b1;
                rd_idx    <= m_axi_araddr[11:2];
                rd_len    <= m_axi_arlen;
                rd_beat   <= 8'd0;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                rd_idx  <= rd_idx + 10'd1;
                rd_beat <= rd_beat + 8'd1;
                if (rd_beat == rd_len) rd_active <= 1'b0;
            end
            if (m_axi_wvalid && !wr_active) w_early++;
            if (m_axi_awvalid && m_axi_awready) begin
                check("awaddr", m_axi_awaddr, exp_addr);
                check("awlen", {24'd0, m_axi_awlen}, {24'd0, exp_len});
                wr_active <= 1'b1;
                wr_idx    <= m_axi_awaddr[11:2];
                wr_beat   <= 8'd0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("wlast", {31'd0, m_axi_wlast}, {31'd0, wr_beat == exp_len});
                for (int b = 0; b < 4; b++)
                    if (m_axi_wstrb[b]) mem[wr_idx][8*b +: 8] = m_axi_wdata[8*b +: 8];
                wr_idx  <= wr_idx + 10'd1;
                wr_beat <= wr_beat + 8'd1;
                if (m_axi_wlast) begin
                    wr_active <= 1'b0;
                    bvalid_r  <= 1'b1;
                end
            end
            if (m_axi_bvalid && m_axi_bready) bvalid_r <= 1'b0;
        end
    end

    // Scoreboard side: one line per delivered read beat and per completion.
    logic done_prev = 1'b0;
    always @(negedge clk_i) begin
        if (rd_valid && rd_ready) begin
            if (rq.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                $display("rd beat data=%h last=%0b", rd_data, rd_last);
                check("rd_data", rd_data, e.data);
                check("rd_last", {31'd0, rd_last}, {31'd0, e.last});
            end
        end
        if (done_valid) begin
            done_cnt++;
            $display("done resp=%0d err=%0b", done_resp, done_err);
            check("done_width", {31'd0, done_prev}, 32'd0);
            check("rd_pending_at_done", rq.size(), 32'd0);
            if (dq.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                logic [2:0] d;
                d = dq.pop_front();
                check("done_resp", {30'd0, done_resp}, {30'd0, d[2:1]});
                check("done_err", {31'd0, done_err}, {31'd0, d[0]});
            end
        end
        done_prev = done_valid;
    end

    task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] strb);
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_len  = len;
        @(posedge clk_i); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_wstrb = strb;
        @(negedge clk_i);
        check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk_i); #1;
        cmd_valid = 1'b0;
        @(negedge clk_i);
        check("addr_valid_latency", {31'd0, we ? m_axi_awvalid : m_axi_arvalid}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit bp);
        int start;
        start = done_cnt;
        issue_cmd(1'b0, addr, len, 4'h0);
        for (int c = 0; c < 2000 && done_cnt == start; c++) begin
            @(posedge clk_i); #1;
            if (bp) rd_ready = ~rd_ready;
        end
        rd_ready = 1'b1;
        check("read_completed", {31'd0, done_cnt != start}, 32'd1);
        check("rd_queue_empty", rq.size(), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb);
        int start;
        int i;
        bit hs;
        start = done_cnt;
        i = 0;
        dq.push_back(3'b000);
        wr_valid = 1'b1;
        wr_data  = wq[0];
        issue_cmd(1'b1, addr, len, strb);
        for (int c = 0; c < 2000 && done_cnt == start; c++) begin
            @(negedge clk_i);
            hs = wr_valid && wr_ready;
            @(posedge clk_i); #1;
            if (hs) begin
                i++;
                if (i > int'(len)) wr_valid = 1'b0;
                else wr_data = wq[i];
            end
        end
        wr_valid = 1'b0;
        check("write_completed", {31'd0, done_cnt != start}, 32'd1);
        check("write_beats", i, int'(len) + 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_valids"}, {26'd0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                                 m_axi_bready, rd_valid, done_valid}, 32'd0);
        check({tag, "_done"}, {29'd0, done_resp, done_err}, 32'd0);
        check({tag, "_wlast_rlast"}, {30'd0, m_axi_wlast, rd_last}, 32'd0);
        check({tag, "_fixed"}, {22'd0, m_axi_arsize, m_axi_arburst, m_axi_awsize, m_axi_awburst},
              {22'd0, 3'b010, 2'b01, 3'b010, 2'b01});
    endtask

    initial begin
        int start;
        int i;
        bit hs;
        for (int k = 0; k < 1024; k++) mem[k] = 32'd0;

        // Reset values.
        repeat (2) @(negedge clk_i);
        check_idle_outputs("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // Single-beat read.
        mem[10'h040] = 32'hCAFE_F00D;
        rq.push_back('{32'hCAFE_F00D, 1'b1});
        dq.push_back(3'b000);
        do_read(32'h100, 8'd0, 1'b0);

        // 4-beat write then read-back.
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(32'h200, 8'd3, 4'hF);
        for (int k = 0; k < 4; k++) rq.push_back('{k + 1, k == 3});
        dq.push_back(3'b000);
        do_read(32'h200, 8'd3, 1'b0);

        // Partial strobe over an all-ones word; low address bits are ignored.
        mem[10'h0C0] = 32'hFFFF_FFFF;
        wq = '{32'h1234_5678};
        do_write(32'h302, 8'd0, 4'h3);
        rq.push_back('{32'hFFFF_5678, 1'b1});
        dq.push_back(3'b000);
        do_read(32'h300, 8'd0, 1'b0);

        // 16-beat read with rd_ready toggling every cycle.
        for (int k = 0; k < 16; k++) begin
            mem[10'h200 + k] = 32'hA500_0000 + 32'(k * 3);
            rq.push_back('{32'hA500_0000 + 32'(k * 3), k == 15});
        end
        dq.push_back(3'b000);
        do_read(32'h800, 8'd15, 1'b1);

        // SLVERR on beat 2 of 4; result must hold after completion.
        err_beat = 9'd1;
        for (int k = 0; k < 4; k++) rq.push_back('{k + 1, k == 3});
        dq.push_back({2'd2, 1'b0});
        do_read(32'h200, 8'd3, 1'b0);
        err_beat = 9'h100;
        repeat (3) @(negedge clk_i);
        check("done_resp_hold", {30'd0, done_resp}, 32'd2);

        // Early rlast on beat 3 of 4: error flagged, all four beats still taken.
        inj_last = 9'd2;
        for (int k = 0; k < 4; k++) rq.push_back('{k + 1, k == 2});
        dq.push_back({2'd0, 1'b1});
        do_read(32'h200, 8'd3, 1'b0);
        inj_last = 9'h100;
        @(negedge clk_i);
        check("done_err_hold", {31'd0, done_err}, 32'd1);

        // Reset while beat 5 of an 8-beat write is on the bus.
        wq = '{32'h50, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56, 32'h57};
        start = done_cnt;
        i = 0;
        wr_valid = 1'b1;
        wr_data  = wq[0];
        issue_cmd(1'b1, 32'h400, 8'd7, 4'hF);
        for (int c = 0; c < 200 && i < 4; c++) begin
            @(negedge clk_i);
            hs = wr_valid && wr_ready;
            @(posedge clk_i); #1;
            if (hs) begin
                i++;
                wr_data = wq[i];
            end
        end
        check("beats_before_reset", i, 32'd4);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("midreset");
        wr_valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        check("no_done_after_abort", done_cnt - start, 32'd0);
        check("mem_beat5_untouched", mem[10'h104], 32'd0);

        // Recovery: a fresh single-beat read.
        rq.push_back('{32'hCAFE_F00D, 1'b1});
        dq.push_back(3'b000);
        do_read(32'h100, 8'd0, 1'b0);

        check("w_before_aw", w_early, 32'd0);
        check("done_queue_empty", dq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
